// File: rtl/pixel_readout_capture.sv
// pixel_readout_capture
// Captures the four per-pixel read strobes of a sensor frame into slot
// registers, commits complete frames into a two-frame ping-pong buffer and
// streams them out one pixel per valid/ready beat.
module pixel_readout_capture #(
  parameter int DATA_W      = 8,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ERASE,
  input  logic                   READ1,
  input  logic                   READ2,
  input  logic                   READ3,
  input  logic                   READ4,
  input  logic [DATA_W-1:0]      DATA_IN,
  output logic [DATA_W-1:0]      PIX_DATA,
  output logic [1:0]             PIX_INDEX,
  output logic                   PIX_LAST,
  output logic                   PIX_VALID,
  input  logic                   PIX_READY,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT,
  output logic                   OVERFLOW,
  output logic                   PROTO_ERR
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t                 r_state, w_state_n;
  logic [3:0]             w_rd, r_rd_prev, r_mask, w_mask_n, w_fall, w_fall_ok;
  logic                   w_multi, r_prev_multi, w_capturing;
  logic [DATA_W-1:0]      r_shadow [4];
  logic [DATA_W-1:0]      r_slot   [4];
  logic [DATA_W-1:0]      r_buf    [2][4];
  logic                   r_wr_ptr, r_rd_ptr, w_rd_ptr_n;
  logic [1:0]             r_occ, w_occ_n, r_idx, w_idx_n;
  logic                   w_xfer, w_last_xfer, w_commit, w_accept, w_perr_set;
  logic [DATA_W-1:0]      w_pix_data_n, r_pix_data;
  logic                   r_pix_valid, r_pix_last, r_overflow, r_proto_err;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  assign w_rd        = {READ4, READ3, READ2, READ1};
  assign w_multi     = (w_rd & (w_rd - 4'd1)) != 4'd0;
  assign w_capturing = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign w_fall      = r_rd_prev & ~w_rd;
  // Falls right after a multi-strobe cycle are ignored so the slots keep
  // their last legally captured values.
  assign w_fall_ok   = (w_capturing && !ERASE && !r_prev_multi) ? w_fall : 4'd0;
  assign w_xfer      = r_pix_valid & PIX_READY;
  assign w_last_xfer = w_xfer && (r_idx == 2'd3);
  assign w_commit    = (r_state == S_COMMIT);
  // A final beat leaving in the commit cycle frees a frame just in time.
  assign w_accept    = w_commit && ((r_occ != 2'd2) || w_last_xfer);
  assign w_perr_set  = (ERASE && (r_state == S_CAPTURE))
                    || ((r_state == S_IDLE) && (w_rd != 4'd0))
                    || (w_capturing && w_multi)
                    || ((w_fall_ok & r_mask) != 4'd0);

  assign PIX_DATA  = r_pix_data;
  assign PIX_INDEX = r_idx;
  assign PIX_LAST  = r_pix_last;
  assign PIX_VALID = r_pix_valid;
  assign FRAME_CNT = r_frame_cnt;
  assign OVERFLOW  = r_overflow;
  assign PROTO_ERR = r_proto_err;

  // Next capture state and slot-filled mask
  always_comb begin
    w_state_n = r_state;
    w_mask_n  = (ERASE || w_commit) ? 4'd0 : (r_mask | w_fall_ok);
    case (r_state)
      S_IDLE: begin
        if (ERASE) w_state_n = S_ARMED;
        else       w_state_n = S_IDLE;
      end
      S_ARMED: begin
        if (ERASE)                  w_state_n = S_ARMED;
        else if (w_rd != 4'd0)      w_state_n = S_CAPTURE;
        else                        w_state_n = S_ARMED;
      end
      S_CAPTURE: begin
        if (ERASE)                  w_state_n = S_ARMED;
        else if (w_mask_n == 4'hF)  w_state_n = S_COMMIT;
        else                        w_state_n = S_CAPTURE;
      end
      S_COMMIT: begin
        if (ERASE) w_state_n = S_ARMED;
        else       w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Next read pointer, occupancy, read index and output pixel lookahead
  always_comb begin
    w_idx_n    = w_xfer ? (r_idx + 2'd1) : r_idx;
    w_rd_ptr_n = w_last_xfer ? ~r_rd_ptr : r_rd_ptr;
    case ({w_accept, w_last_xfer})
      2'b10:   w_occ_n = r_occ + 2'd1;
      2'b01:   w_occ_n = r_occ - 2'd1;
      default: w_occ_n = r_occ;
    endcase
    if (w_occ_n == 2'd0)
      w_pix_data_n = {DATA_W{1'b0}};
    else if (w_accept && (r_wr_ptr == w_rd_ptr_n))
      w_pix_data_n = r_slot[w_idx_n];   // frame being written becomes the read frame
    else
      w_pix_data_n = r_buf[w_rd_ptr_n][w_idx_n];
  end

  // Capture state register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Strobe history, shadow registers, slot mask and captured slots
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rd_prev    <= 4'd0;
      r_prev_multi <= 1'b0;
      r_mask       <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= {DATA_W{1'b0}};
        r_slot[i]   <= {DATA_W{1'b0}};
      end
    end else begin
      r_rd_prev    <= w_rd;
      r_prev_multi <= w_multi;
      r_mask       <= w_mask_n;
      for (int i = 0; i < 4; i++) begin
        if (w_capturing && !w_multi && w_rd[i]) r_shadow[i] <= DATA_IN;
        if (w_fall_ok[i])                       r_slot[i]   <= r_shadow[i];
      end
    end
  end

  // Ping-pong frame buffer, pointers, occupancy and read index
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
      r_idx    <= 2'd0;
      for (int f = 0; f < 2; f++)
        for (int i = 0; i < 4; i++)
          r_buf[f][i] <= {DATA_W{1'b0}};
    end else begin
      if (w_accept) begin
        for (int i = 0; i < 4; i++) r_buf[r_wr_ptr][i] <= r_slot[i];
        r_wr_ptr <= ~r_wr_ptr;
      end
      r_rd_ptr <= w_rd_ptr_n;
      r_occ    <= w_occ_n;
      r_idx    <= w_idx_n;
    end
  end

  // Registered output beat, frame counter and sticky error flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_pix_data  <= {DATA_W{1'b0}};
      r_frame_cnt <= {FRAME_CNT_W{1'b0}};
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_pix_valid <= (w_occ_n != 2'd0);
      r_pix_last  <= (w_occ_n != 2'd0) && (w_idx_n == 2'd3);
      r_pix_data  <= w_pix_data_n;
      if (w_accept)             r_frame_cnt <= r_frame_cnt + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      if (w_commit && !w_accept) r_overflow <= 1'b1;
      if (w_perr_set)           r_proto_err <= 1'b1;
    end
  end

endmodule
